// File: rtl/piradip_axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : piradip_axis_rr_arbiter
// Brief    : Round-robin burst arbiter merging N_IN AXI-stream inputs onto one
//            fully registered output; TDEST carries the source index.
// Revision : 1.0 - initial release
// ============================================================================
module piradip_axis_rr_arbiter #(
    parameter int N_IN      = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [N_IN-1:0]         s_axis_tvalid,
    output logic [N_IN-1:0]         s_axis_tready,
    input  logic [N_IN*WIDTH-1:0]   s_axis_tdata,
    input  logic [N_IN-1:0]         s_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [WIDTH-1:0]        m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic [$clog2(N_IN)-1:0] m_axis_tdest,
    output logic                    busy
);

    localparam int c_dest_w = $clog2(N_IN);
    // MAX_BURST = 0 means unlimited; the counter still needs a legal width.
    localparam int c_cnt_w  = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_last_beat =
        (MAX_BURST > 0) ? c_cnt_w'(MAX_BURST - 1) : '0;

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_grant = 1'b1;

    logic [0:0]          r_state;
    logic [c_dest_w-1:0] r_grant;
    logic [c_dest_w-1:0] r_last_grant;
    logic [c_cnt_w-1:0]  r_beat_cnt;
    logic                r_m_tvalid;
    logic [WIDTH-1:0]    r_m_tdata;
    logic                r_m_tlast;
    logic [c_dest_w-1:0] r_m_tdest;

    logic [c_dest_w-1:0] w_arb_idx;
    logic [c_dest_w-1:0] w_cand;
    logic                w_arb_hit;
    logic                w_out_free;
    logic                w_accept;
    logic                w_beat_last;
    logic [WIDTH-1:0]    w_sel_data;

    // Scan starting just after the previous winner, wrapping modulo N_IN.
    always_comb begin
        w_arb_idx = r_last_grant;
        w_arb_hit = 1'b0;
        w_cand    = '0;
        for (int k = 1; k <= N_IN; k++) begin
            w_cand = c_dest_w'((int'(r_last_grant) + k) % N_IN);
            if (!w_arb_hit && s_axis_tvalid[w_cand]) begin
                w_arb_hit = 1'b1;
                w_arb_idx = w_cand;
            end
        end
    end

    assign w_out_free  = m_axis_tready | ~r_m_tvalid;
    assign w_accept    = (r_state == c_st_grant) & s_axis_tvalid[r_grant] & w_out_free;
    assign w_sel_data  = s_axis_tdata[r_grant*WIDTH +: WIDTH];
    assign w_beat_last = s_axis_tlast[r_grant] |
                         ((MAX_BURST != 0) && (r_beat_cnt == c_last_beat));

    always_comb begin
        s_axis_tready = '0;
        if (r_state == c_st_grant) begin
            s_axis_tready[r_grant] = w_out_free;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state      <= c_st_idle;
            r_grant      <= '0;
            r_last_grant <= c_dest_w'(N_IN - 1);
            r_beat_cnt   <= '0;
            r_m_tvalid   <= 1'b0;
            r_m_tdata    <= '0;
            r_m_tlast    <= 1'b0;
            r_m_tdest    <= '0;
        end else begin
            if (w_accept) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= w_sel_data;
                r_m_tlast  <= w_beat_last;
                r_m_tdest  <= r_grant;
                r_beat_cnt <= r_beat_cnt + 1'b1;
                if (w_beat_last) begin
                    r_state <= c_st_idle;
                end
            end else if (m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end

            // Arbitration does not wait for a pending output beat to drain.
            if ((r_state == c_st_idle) && w_arb_hit) begin
                r_state      <= c_st_grant;
                r_grant      <= w_arb_idx;
                r_last_grant <= w_arb_idx;
                r_beat_cnt   <= '0;
            end
        end
    end

    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tdest  = r_m_tdest;
    assign busy          = (r_state == c_st_grant);

endmodule
`default_nettype wire

// File: tb/tb_piradip_axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_piradip_axis_rr_arbiter
// Brief    : Vector table, backpressure sequence and randomized model check
//            for piradip_axis_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piradip_axis_rr_arbiter;

    localparam logic [31:0] c_tag = 32'hC0DE_0000;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A: N_IN=4, MAX_BURST=4 ----------------
    logic         r_a_rstn;
    logic [3:0]   r_a_vld;
    logic [3:0]   r_a_lst;
    logic         r_a_mrdy;
    logic [31:0]  r_a_dat [4];
    logic [127:0] w_a_tdata;
    logic [3:0]   w_a_srdy;
    logic         w_a_mvld;
    logic [31:0]  w_a_mdata;
    logic         w_a_mlast;
    logic [1:0]   w_a_mdest;
    logic         w_a_busy;

    always_comb begin
        w_a_tdata = '0;
        for (int i = 0; i < 4; i++) w_a_tdata[i*32 +: 32] = r_a_dat[i];
    end

    piradip_axis_rr_arbiter #(.N_IN(4), .WIDTH(32), .MAX_BURST(4)) u_dut_a (
        .aclk          (clk),
        .aresetn       (r_a_rstn),
        .s_axis_tvalid (r_a_vld),
        .s_axis_tready (w_a_srdy),
        .s_axis_tdata  (w_a_tdata),
        .s_axis_tlast  (r_a_lst),
        .m_axis_tvalid (w_a_mvld),
        .m_axis_tready (r_a_mrdy),
        .m_axis_tdata  (w_a_mdata),
        .m_axis_tlast  (w_a_mlast),
        .m_axis_tdest  (w_a_mdest),
        .busy          (w_a_busy)
    );

    // ---------------- instance B: N_IN=3, MAX_BURST=0 ----------------
    logic        r_b_rstn;
    logic [2:0]  r_b_vld;
    logic [2:0]  r_b_lst;
    logic        r_b_mrdy;
    logic [31:0] r_b_dat [3];
    logic [95:0] w_b_tdata;
    logic [2:0]  w_b_srdy;
    logic        w_b_mvld;
    logic [31:0] w_b_mdata;
    logic        w_b_mlast;
    logic [1:0]  w_b_mdest;
    logic        w_b_busy;

    always_comb begin
        w_b_tdata = '0;
        for (int i = 0; i < 3; i++) w_b_tdata[i*32 +: 32] = r_b_dat[i];
    end

    piradip_axis_rr_arbiter #(.N_IN(3), .WIDTH(32), .MAX_BURST(0)) u_dut_b (
        .aclk          (clk),
        .aresetn       (r_b_rstn),
        .s_axis_tvalid (r_b_vld),
        .s_axis_tready (w_b_srdy),
        .s_axis_tdata  (w_b_tdata),
        .s_axis_tlast  (r_b_lst),
        .m_axis_tvalid (w_b_mvld),
        .m_axis_tready (r_b_mrdy),
        .m_axis_tdata  (w_b_mdata),
        .m_axis_tlast  (w_b_mlast),
        .m_axis_tdest  (w_b_mdest),
        .busy          (w_b_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rstn;
        logic [3:0] vld;
        logic [3:0] lst;
        logic       rdy;
        logic [3:0] e_srdy;
        logic       e_vld;
        logic [1:0] e_dest;
        logic       e_last;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rstn, input logic [3:0] vld, input logic [3:0] lst,
                       input logic rdy, input logic [3:0] e_srdy, input logic e_vld,
                       input logic [1:0] e_dest, input logic e_last, input logic e_busy);
        vec_t v;
        v.rstn = rstn; v.vld = vld; v.lst = lst; v.rdy = rdy;
        v.e_srdy = e_srdy; v.e_vld = e_vld; v.e_dest = e_dest;
        v.e_last = e_last; v.e_busy = e_busy;
        tbl.push_back(v);
    endtask

    // Round-robin choice straight from the fairness rule.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
        logic [1:0] pick;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (int'(last) + k) % 3;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = 2'(idx);
            end
        end
        return pick;
    endfunction

    // backpressure sequence state
    int          seq, exp_cnt, stalls;
    logic        hs_in, hs_out, stall;
    logic [31:0] snap_data;
    logic [1:0]  snap_dest;
    logic        snap_last;

    // random test model state
    logic        m_busy, m_vld, m_lst;
    logic [1:0]  m_grant, m_lastg, m_src;
    logic [31:0] m_data;
    logic        p_arb, p_rdy, p_out;
    logic [1:0]  p_grant;
    logic [2:0]  p_in, exp_srdy;
    int          wait_cnt [3];
    int          out_seq  [3];
    int          gen_seq  [3];
    int          beats, cyc;

    initial begin
        r_a_rstn = 1'b0; r_a_vld = '0; r_a_lst = '0; r_a_mrdy = 1'b1;
        r_b_rstn = 1'b0; r_b_vld = '0; r_b_lst = '0; r_b_mrdy = 1'b1;
        for (int i = 0; i < 4; i++) r_a_dat[i] = c_tag | 32'(i);
        for (int i = 0; i < 3; i++) r_b_dat[i] = '0;

        // reset + two interleaved 3-beat packets on inputs 0 and 2
        add(1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
        add(1'b1, 4'h5, 4'h0, 1'b1, 4'h1, 1'b0, 2'd0, 1'b0, 1'b1);
        add(1'b1, 4'h5, 4'h0, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0, 1'b1);
        add(1'b1, 4'h5, 4'h0, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0, 1'b1);
        add(1'b1, 4'h5, 4'h1, 1'b1, 4'h0, 1'b1, 2'd0, 1'b1, 1'b0);
        add(1'b1, 4'h4, 4'h0, 1'b1, 4'h4, 1'b0, 2'd0, 1'b0, 1'b1);
        add(1'b1, 4'h4, 4'h0, 1'b1, 4'h4, 1'b1, 2'd2, 1'b0, 1'b1);
        add(1'b1, 4'h4, 4'h0, 1'b1, 4'h4, 1'b1, 2'd2, 1'b0, 1'b1);
        add(1'b1, 4'h4, 4'h4, 1'b1, 4'h0, 1'b1, 2'd2, 1'b1, 1'b0);
        add(1'b1, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
        // all inputs busy, no TLAST: MAX_BURST bursts rotating 0,1,2,3,0
        add(1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++) begin
            logic [1:0] g;
            g = 2'(n % 4);
            add(1'b1, 4'hF, 4'h0, 1'b1, 4'(1 << g), 1'b0, 2'd0, 1'b0, 1'b1);
            for (int b = 1; b <= 4; b++)
                add(1'b1, 4'hF, 4'h0, 1'b1, (b < 4) ? 4'(1 << g) : 4'h0,
                    1'b1, g, (b == 4), (b != 4));
        end
        // only input 3 requests: two packets, granted back to back
        add(1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
        add(1'b1, 4'h8, 4'h0, 1'b1, 4'h8, 1'b0, 2'd0, 1'b0, 1'b1);
        add(1'b1, 4'h8, 4'h0, 1'b1, 4'h8, 1'b1, 2'd3, 1'b0, 1'b1);
        add(1'b1, 4'h8, 4'h8, 1'b1, 4'h0, 1'b1, 2'd3, 1'b1, 1'b0);
        add(1'b1, 4'h8, 4'h0, 1'b1, 4'h8, 1'b0, 2'd0, 1'b0, 1'b1);
        add(1'b1, 4'h8, 4'h0, 1'b1, 4'h8, 1'b1, 2'd3, 1'b0, 1'b1);
        add(1'b1, 4'h8, 4'h8, 1'b1, 4'h0, 1'b1, 2'd3, 1'b1, 1'b0);
        add(1'b1, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
        // reset mid-burst on input 1: restart from the lowest requester
        add(1'b0, 4'h6, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
        add(1'b1, 4'h6, 4'h0, 1'b1, 4'h2, 1'b0, 2'd0, 1'b0, 1'b1);
        add(1'b1, 4'h6, 4'h0, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0, 1'b1);
        add(1'b0, 4'h6, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
        add(1'b1, 4'h6, 4'h0, 1'b1, 4'h2, 1'b0, 2'd0, 1'b0, 1'b1);
        add(1'b1, 4'h6, 4'h0, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0, 1'b1);

        @(negedge clk);
        for (int r = 0; r < tbl.size(); r++) begin
            r_a_rstn = tbl[r].rstn;
            r_a_vld  = tbl[r].vld;
            r_a_lst  = tbl[r].lst;
            r_a_mrdy = tbl[r].rdy;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("row%0d_s_tready", r), 64'(w_a_srdy), 64'(tbl[r].e_srdy));
            chk($sformatf("row%0d_m_tvalid", r), 64'(w_a_mvld), 64'(tbl[r].e_vld));
            chk($sformatf("row%0d_busy", r),     64'(w_a_busy), 64'(tbl[r].e_busy));
            if (tbl[r].e_vld) begin
                chk($sformatf("row%0d_tdest", r), 64'(w_a_mdest), 64'(tbl[r].e_dest));
                chk($sformatf("row%0d_tlast", r), 64'(w_a_mlast), 64'(tbl[r].e_last));
                chk($sformatf("row%0d_tdata", r), 64'(w_a_mdata), 64'(c_tag | 32'(tbl[r].e_dest)));
            end
            if (!tbl[r].rstn) begin
                chk($sformatf("row%0d_rst_tdata", r), 64'(w_a_mdata), 64'd0);
                chk($sformatf("row%0d_rst_tdest", r), 64'(w_a_mdest), 64'd0);
                chk($sformatf("row%0d_rst_tlast", r), 64'(w_a_mlast), 64'd0);
            end
        end

        // ---- backpressure: m_axis_tready low for 5 cycles inside a burst ----
        r_a_rstn = 1'b0; r_a_vld = '0; r_a_lst = '0; r_a_mrdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_a_rstn = 1'b1;
        seq = 0; exp_cnt = 0; stalls = 0;
        for (int c = 0; c < 30; c++) begin
            r_a_vld    = (c < 24) ? 4'b0010 : 4'b0000;
            r_a_mrdy   = (c >= 5 && c < 10) ? 1'b0 : 1'b1;
            r_a_dat[1] = 32'h100 + 32'(seq);
            #1;
            hs_in     = r_a_vld[1] & w_a_srdy[1];
            hs_out    = w_a_mvld & r_a_mrdy;
            stall     = w_a_mvld & ~r_a_mrdy;
            snap_data = w_a_mdata;
            snap_dest = w_a_mdest;
            snap_last = w_a_mlast;
            if (stall) begin
                stalls++;
                chk("bp_s_tready_low", 64'(w_a_srdy[1]), 64'd0);
            end
            if (hs_out) begin
                chk("bp_tdata", 64'(snap_data), 64'(32'h100 + 32'(exp_cnt)));
                chk("bp_tdest", 64'(snap_dest), 64'd1);
                chk("bp_tlast", 64'(snap_last), 64'((exp_cnt % 4) == 3));
                exp_cnt++;
            end
            @(posedge clk);
            @(negedge clk);
            if (hs_in) seq++;
            if (stall) begin
                chk("bp_hold_tvalid", 64'(w_a_mvld),  64'd1);
                chk("bp_hold_tdata",  64'(w_a_mdata), 64'(snap_data));
                chk("bp_hold_tdest",  64'(w_a_mdest), 64'(snap_dest));
                chk("bp_hold_tlast",  64'(w_a_mlast), 64'(snap_last));
            end
        end
        chk("bp_beats_in_eq_out", 64'(exp_cnt), 64'(seq));
        chk("bp_stall_cycles", 64'(stalls), 64'd5);

        // ---- randomized traffic on B against the behavioural model ----
        repeat (2) @(negedge clk);
        r_b_rstn = 1'b1;
        m_busy = 1'b0; m_vld = 1'b0; m_lst = 1'b0; m_data = '0;
        m_grant = '0; m_lastg = 2'd2; m_src = '0;
        p_arb = 1'b0; p_rdy = 1'b0; p_out = 1'b0; p_in = '0; p_grant = '0;
        for (int i = 0; i < 3; i++) begin
            wait_cnt[i] = 0; out_seq[i] = 0; gen_seq[i] = 0;
        end
        beats = 0; cyc = 0;
        while (beats < 10000 && cyc < 60000) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            // advance the model across the edge just taken
            if (p_in[m_grant]) begin
                m_vld  = 1'b1;
                m_data = r_b_dat[m_grant];
                m_lst  = r_b_lst[m_grant];
                m_src  = m_grant;
                if (r_b_lst[m_grant]) m_busy = 1'b0;
            end else if (p_rdy) begin
                m_vld = 1'b0;
            end
            if (p_arb) begin
                m_busy  = 1'b1;
                m_grant = p_grant;
                m_lastg = p_grant;
            end

            chk("rnd_tvalid", 64'(w_b_mvld), 64'(m_vld));
            chk("rnd_busy",   64'(w_b_busy), 64'(m_busy));
            if (m_vld) begin
                chk("rnd_tdata", 64'(w_b_mdata), 64'(m_data));
                chk("rnd_tdest", 64'(w_b_mdest), 64'(m_src));
                chk("rnd_tlast", 64'(w_b_mlast), 64'(m_lst));
            end

            // sources hold a beat until it is taken, then maybe offer another
            for (int i = 0; i < 3; i++) begin
                if (!(r_b_vld[i] && !p_in[i])) begin
                    if ($urandom % 4 != 0) begin
                        r_b_vld[i] = 1'b1;
                        r_b_dat[i] = {8'(i), 24'(gen_seq[i])};
                        r_b_lst[i] = ($urandom % 4 == 0);
                        gen_seq[i]++;
                    end else begin
                        r_b_vld[i] = 1'b0;
                    end
                end
            end
            r_b_mrdy = ($urandom % 4 != 0);
            #1;

            // predict what the coming edge will do
            exp_srdy = m_busy ? 3'(((r_b_mrdy | ~m_vld) ? 3'b001 : 3'b000) << m_grant) : 3'b000;
            chk("rnd_s_tready", 64'(w_b_srdy), 64'(exp_srdy));
            p_rdy = r_b_mrdy;
            p_out = m_vld & r_b_mrdy;
            p_in  = r_b_vld & exp_srdy;
            p_arb = !m_busy && (r_b_vld != 3'b000);
            if (p_out) begin
                chk("rnd_src_field", 64'(w_b_mdata[31:24]), 64'(w_b_mdest));
                if (w_b_mdest < 2'd3) begin
                    chk("rnd_src_order", 64'(w_b_mdata[23:0]), 64'(24'(out_seq[w_b_mdest])));
                    out_seq[w_b_mdest]++;
                end
                beats++;
            end
            if (p_arb) begin
                p_grant = rr_pick(m_lastg, r_b_vld);
                for (int i = 0; i < 3; i++) begin
                    if (2'(i) == p_grant || !r_b_vld[i]) begin
                        wait_cnt[i] = 0;
                    end else begin
                        wait_cnt[i]++;
                        chk($sformatf("rnd_starve%0d", i), 64'(wait_cnt[i] <= 2), 64'd1);
                    end
                end
            end
        end
        chk("rnd_beat_budget", 64'(beats >= 10000), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
